axi_lite_master_ctrl: RTL

Sequences single AXI4-Lite transactions from the LSU's memory-mapped AXI command registers (address, data, select, strobe, control). The LSU writes a command; this block runs the AW/W/B or AR/R handshakes, then returns read data, response code and status for the LSU to read back. It sits beside the LSU in the MEM stage and owns the external AXI4-Lite master port.

---
 rtl/axi_ctrl_pkg.sv | 27 ++
 rtl/axi_watchdog.sv | 36 +++
 rtl/axi_lite_master_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_ctrl_pkg
// Description : Shared types and constants for the AXI4-Lite master control.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    localparam logic [1:0] CTRL_IDLE = 2'b00;
    localparam logic [1:0] CTRL_WR   = 2'b01;
    localparam logic [1:0] CTRL_RD   = 2'b10;
    localparam logic [1:0] CTRL_RSV  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/axi_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : axi_watchdog
// Description : Saturating idle-cycle counter; flags expiry at TIMEOUT.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_limit = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;

    // Holds at the limit so a stalled transaction stays expired until cleared.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q <= '0;
        end else if (i_clr) begin
            cnt_q <= '0;
        end else if (i_en && (cnt_q != c_limit)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign o_expired = (cnt_q == c_limit);

endmodule
`default_nettype wire

// File: rtl/axi_lite_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_master_ctrl
// Description : Runs one AXI4-Lite write or read per LSU command and reports
//               read data, response code and status back to the LSU.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_master_ctrl
    import axi_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [ADDR_W-1:0]   i_cmd_addr,
    input  logic [DATA_W-1:0]   i_cmd_data,
    input  logic                i_cmd_sel,
    input  logic [DATA_W/8-1:0] i_cmd_strobe,
    input  logic [1:0]          i_cmd_ctrl,
    output logic [ADDR_W-1:0]   o_awaddr,
    output logic                o_awvalid,
    input  logic                i_awready,
    output logic [DATA_W-1:0]   o_wdata,
    output logic [DATA_W/8-1:0] o_wstrb,
    output logic                o_wvalid,
    input  logic                i_wready,
    input  logic [1:0]          i_bresp,
    input  logic                i_bvalid,
    output logic                o_bready,
    output logic [ADDR_W-1:0]   o_araddr,
    output logic                o_arvalid,
    input  logic                i_arready,
    input  logic [DATA_W-1:0]   i_rdata,
    input  logic [1:0]          i_rresp,
    input  logic                i_rvalid,
    output logic                o_rready,
    output logic                o_busy,
    output logic                o_done,
    output logic [DATA_W-1:0]   o_rd_data,
    output logic [1:0]          o_resp,
    output logic                o_timeout
);

    localparam int STRB_W = DATA_W / 8;

    state_e              state_q;
    logic                armed_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [STRB_W-1:0]   strb_q;
    logic                awvalid_q;
    logic                wvalid_q;
    logic                bready_q;
    logic                arvalid_q;
    logic                rready_q;
    logic                busy_q;
    logic                done_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic [1:0]          resp_q;
    logic                timeout_q;

    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_any_hs;
    logic w_active, w_launch, w_rearm, w_expired, w_wd_clr;

    assign w_aw_hs  = awvalid_q & i_awready;
    assign w_w_hs   = wvalid_q  & i_wready;
    assign w_b_hs   = bready_q  & i_bvalid;
    assign w_ar_hs  = arvalid_q & i_arready;
    assign w_r_hs   = rready_q  & i_rvalid;
    assign w_any_hs = w_aw_hs | w_w_hs | w_b_hs | w_ar_hs | w_r_hs;

    assign w_active = (state_q == ST_WR) || (state_q == ST_WR_RESP) ||
                      (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA);

    assign w_launch = (state_q == ST_IDLE) && armed_q && i_cmd_sel &&
                      ((i_cmd_ctrl == CTRL_WR) || (i_cmd_ctrl == CTRL_RD));
    assign w_rearm  = !i_cmd_sel || (i_cmd_ctrl == CTRL_IDLE);

    // Every active state is entered either from IDLE or through a handshake,
    // so clearing outside the active states plus on handshakes covers entries.
    assign w_wd_clr = w_any_hs | ~w_active;

    axi_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (w_wd_clr),
        .i_en      (w_active),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= ST_IDLE;
            armed_q   <= 1'b1;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= '0;
            resp_q    <= RESP_OKAY;
            timeout_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (w_rearm) begin
                armed_q <= 1'b1;
            end

            if (w_active && w_expired) begin
                awvalid_q <= 1'b0;
                wvalid_q  <= 1'b0;
                bready_q  <= 1'b0;
                arvalid_q <= 1'b0;
                rready_q  <= 1'b0;
                resp_q    <= RESP_SLVERR;
                timeout_q <= 1'b1;
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
                state_q   <= ST_DONE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (w_launch) begin
                            armed_q   <= 1'b0;
                            timeout_q <= 1'b0;
                            addr_q    <= i_cmd_addr;
                            data_q    <= i_cmd_data;
                            strb_q    <= i_cmd_strobe;
                            busy_q    <= 1'b1;
                            if (i_cmd_ctrl == CTRL_WR) begin
                                awvalid_q <= 1'b1;
                                wvalid_q  <= 1'b1;
                                state_q   <= ST_WR;
                            end else begin
                                arvalid_q <= 1'b1;
                                state_q   <= ST_RD_ADDR;
                            end
                        end
                    end
                    ST_WR: begin
                        // AW and W complete independently; leave once both are done.
                        if ((w_aw_hs || !awvalid_q) && (w_w_hs || !wvalid_q)) begin
                            awvalid_q <= 1'b0;
                            wvalid_q  <= 1'b0;
                            bready_q  <= 1'b1;
                            state_q   <= ST_WR_RESP;
                        end else begin
                            if (w_aw_hs) awvalid_q <= 1'b0;
                            if (w_w_hs)  wvalid_q  <= 1'b0;
                        end
                    end
                    ST_WR_RESP: begin
                        if (w_b_hs) begin
                            bready_q <= 1'b0;
                            resp_q   <= i_bresp;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= ST_DONE;
                        end
                    end
                    ST_RD_ADDR: begin
                        if (w_ar_hs) begin
                            arvalid_q <= 1'b0;
                            rready_q  <= 1'b1;
                            state_q   <= ST_RD_DATA;
                        end
                    end
                    ST_RD_DATA: begin
                        if (w_r_hs) begin
                            rready_q  <= 1'b0;
                            rd_data_q <= i_rdata;
                            resp_q    <= i_rresp;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_awaddr  = addr_q;
    assign o_araddr  = addr_q;
    assign o_wdata   = data_q;
    assign o_wstrb   = strb_q;
    assign o_awvalid = awvalid_q;
    assign o_wvalid  = wvalid_q;
    assign o_bready  = bready_q;
    assign o_arvalid = arvalid_q;
    assign o_rready  = rready_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_rd_data = rd_data_q;
    assign o_resp    = resp_q;
    assign o_timeout = timeout_q;

endmodule
`default_nettype wire
